// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared FSM state encoding, default input clock and reset half-period helper.
package clk_div_ctrl_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        DONE     = 2'd3
    } state_t;

    function automatic int def_half(int clk_freq, int def_freq);
        return clk_freq / (2 * def_freq);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: enable-gated half-period counter with output toggle flop; rise/fall flag the toggle about to happen.
module clk_div_core #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] half,
    output logic             clk_div,
    output logic             rise,
    output logic             fall
);
    logic [DIV_W-1:0] count;
    logic             wrap;

    assign wrap = en && !clr && (count == half - DIV_W'(1));
    assign rise = wrap && !clk_div;
    assign fall = wrap && clk_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            clk_div <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            clk_div <= 1'b0;
        end else if (en) begin
            count   <= wrap ? '0 : count + DIV_W'(1);
            clk_div <= clk_div ^ wrap;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with shadowed config, burst/continuous runs and clean stop.
// Define DIV_STATUS_EN to expose cur_half and period_cnt status ports.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int DIV_W    = 32,
    parameter int DEF_FREQ = 1_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_half,
    input  logic [15:0]      cfg_burst,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             clk_div,
    output logic             tick,
    output logic             busy,
    output logic             done
`ifdef DIV_STATUS_EN
    ,
    output logic [DIV_W-1:0] cur_half,
    output logic [15:0]      period_cnt
`endif
);
    localparam logic [DIV_W-1:0] DEF_HALF = DIV_W'(def_half(CLK_FREQ, DEF_FREQ));

    state_t           state, nxt;
    logic [DIV_W-1:0] active_half, shadow_half;
    logic [15:0]      active_burst, shadow_burst, periods;
    logic             pending, accept, good, en, clr, rise, fall, last;

    assign accept = cfg_valid && cfg_ready;
    assign good   = accept && (cfg_half != '0);
    assign en     = (state == RUN) || (state == STOPPING);
    // Parking a low output in STOPPING stops the counter before it can start a runt high pulse.
    assign clr    = (state == IDLE) || (state == DONE) || (state == STOPPING && !clk_div);
    assign last   = fall && (active_burst != '0) && (periods + 16'd1 == active_burst);

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .half    (active_half),
        .clk_div (clk_div),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE     ? (start ? RUN : IDLE) :
              state == RUN      ? (last ? DONE : stop ? STOPPING : RUN) :
              state == STOPPING ? ((!clk_div || fall) ? IDLE : STOPPING) :
                                  IDLE;
    end

    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        cfg_ready = state == IDLE ? 1'b1 : state == DONE ? 1'b0 : !pending;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_half  <= DEF_HALF;
            active_burst <= '0;
            shadow_half  <= DEF_HALF;
            shadow_burst <= '0;
            pending      <= 1'b0;
            periods      <= '0;
            tick         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err <= accept && (cfg_half == '0);
            tick    <= rise;
            if (good && state == IDLE) begin
                active_half  <= cfg_half;
                active_burst <= cfg_burst;
            end else if (good) begin
                shadow_half  <= cfg_half;
                shadow_burst <= cfg_burst;
                pending      <= 1'b1;
            end
            if (state == IDLE && start) begin
                periods <= '0;
            end else if (fall && pending) begin
                active_half  <= shadow_half;
                active_burst <= shadow_burst;
                pending      <= 1'b0;
                periods      <= '0;
            end else if (fall) begin
                periods <= periods + 16'd1;
            end
        end
    end

`ifdef DIV_STATUS_EN
    assign cur_half   = active_half;
    assign period_cnt = periods;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench; expected tick/done/cfg_err cycles come from period arithmetic.
module tb_clk_div_ctrl;
    localparam int K_TICK = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int DEF_H  = 25_000;

    logic        clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
    logic [31:0] cfg_half = '0;
    logic [15:0] cfg_burst = '0;
    logic        cfg_ready, cfg_err, clk_div, tick, busy, done;
`ifdef DIV_STATUS_EN
    logic [31:0] cur_half;
    logic [15:0] period_cnt;
`endif

    clk_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_burst (cfg_burst),
        .cfg_err   (cfg_err),
        .start     (start),
        .stop      (stop),
        .clk_div   (clk_div),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
`ifdef DIV_STATUS_EN
        ,
        .cur_half  (cur_half),
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;
    ev_t q[$];

    int checks = 0, failures = 0;
    int m_half = DEF_H;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(int k, int t);
        q.push_back(ev_t'{kind: k, at: t});
    endtask

    task automatic sb(int k);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected event: kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
            e = q.pop_front();
            chk("event kind", k, e.kind);
            chk("event cycle", cyc, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tick) sb(K_TICK);
            if (done) sb(K_DONE);
            if (cfg_err) sb(K_ERR);
        end
    end

    // Output level after edge t of a run entered at edge r: one toggle every h cycles.
    function automatic int lvl(int r, int h, int t);
        return ((t - r) / h) % 2;
    endfunction

    task automatic push_ticks(int r, int h, int lo, int hi);
        for (int t = r + h; t <= hi; t += 2 * h)
            if (t >= lo) push(K_TICK, t);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic cfg_offer(int h, int b);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_half  = h;
        cfg_burst = b[15:0];
        chk("cfg_ready in idle", cfg_ready, 1);
        if (h == 0) push(K_ERR, cyc + 1);
        else m_half = h;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start(output int r);
        @(negedge clk);
        start = 1'b1;
        r = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy after start", busy, 1);
    endtask

    task automatic stop_run(int r, int h, int lo, int c);
        int e;
        e = lvl(r, h, c + 1) == 0 ? c + 2 : r + h * ((c + 1 - r) / h + 1);
        push_ticks(r, h, lo, c + 1);
        wait_cyc(c);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cyc(e - 1);
        chk("busy while stopping", busy, 1);
        wait_cyc(e);
        chk("busy after stop", busy, 0);
        chk("clk_div after stop", clk_div, 0);
    endtask

    task automatic burst_run(int h, int n);
        int r;
        cfg_offer(h, n);
        do_start(r);
        push_ticks(r, h, r + 1, r + 2 * h * n - h);
        push(K_DONE, r + 2 * h * n);
        wait_cyc(r + 2 * h * n);
        chk("cfg_ready in done", cfg_ready, 0);
        chk("clk_div in done", clk_div, 0);
        wait_cyc(r + 2 * h * n + 1);
        chk("busy after done", busy, 0);
        chk("cfg_ready after done", cfg_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, h;
        repeat (3) @(negedge clk);
        chk("reset clk_div", clk_div, 0);
        chk("reset tick", tick, 0);
        chk("reset done", done, 0);
        chk("reset cfg_err", cfg_err, 0);
        chk("reset busy", busy, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        // Default half period after reset, then asynchronous reset while high.
        do_start(r);
        push(K_TICK, r + DEF_H);
        wait_cyc(r + DEF_H - 1);
        chk("default clk_div low", clk_div, 0);
        wait_cyc(r + DEF_H);
        chk("default clk_div high", clk_div, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst clk_div", clk_div, 0);
        chk("async rst busy", busy, 0);
        chk("async rst tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        m_half = DEF_H;

        // Continuous half=4: full waveform, then stop in a low phase.
        cfg_offer(4, 0);
        do_start(r);
        push_ticks(r, 4, r + 1, r + 23);
        for (int t = r; t <= r + 23; t++) begin
            wait_cyc(t);
            chk("clk_div level h4", clk_div, lvl(r, 4, t));
        end
        stop_run(r, 4, r + 24, r + 26);

        // Half=6, stop two cycles into the high phase.
        cfg_offer(6, 0);
        do_start(r);
        stop_run(r, 6, r + 1, r + 7);

        burst_run(3, 2);

        // Reconfigure mid-high phase at half=5 to half=2.
        cfg_offer(5, 0);
        do_start(r);
        push(K_TICK, r + 5);
        wait_cyc(r + 6);
        cfg_valid = 1'b1;
        cfg_half  = 2;
        cfg_burst = 0;
        chk("cfg_ready before shadow", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready pending", cfg_ready, 0);
        wait_cyc(r + 9);
        chk("old period high", clk_div, 1);
        chk("cfg_ready still pending", cfg_ready, 0);
        wait_cyc(r + 10);
        chk("clk_div at switch", clk_div, 0);
        chk("cfg_ready after switch", cfg_ready, 1);
        m_half = 2;
        stop_run(r + 10, 2, r + 11, r + 19);

        // Illegal half is rejected and the previous half stays in force.
        cfg_offer(0, 0);
        do_start(r);
        stop_run(r, m_half, r + 1, r + 9);

        repeat (8) begin
            h = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) begin
                burst_run(h, int'($urandom_range(1, 3)));
            end else begin
                cfg_offer(h, 0);
                do_start(r);
                stop_run(r, h, r + 1, r + int'($urandom_range(0, 30)));
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
